// File: rtl/fft32_pkg.sv
// Shared constants, state encoding, bit-reversal and inverse twiddle ROM
// for the 32-point iterative inverse FFT.
package fft32_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned FRAC_BITS      = 16;
    localparam int unsigned LOG2_NFFT      = 5;
    localparam int unsigned NFFT_POINTS    = 32;
    localparam int unsigned ADDR_W         = LOG2_NFFT;
    localparam int unsigned TW_W           = LOG2_NFFT - 1;
    localparam int unsigned STEP_W         = 7;
    localparam int unsigned COMPUTE_CYCLES = LOG2_NFFT * (NFFT_POINTS / 2);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } cplx_t;

    function automatic logic [ADDR_W-1:0] bitrev5(input logic [ADDR_W-1:0] a);
        return {a[0], a[1], a[2], a[3], a[4]};
    endfunction

    // Wi[k] = cos(2*pi*k/32) + j*sin(2*pi*k/32), Q16.16 rounded to nearest
    function automatic cplx_t twiddle_inv(input logic [TW_W-1:0] k);
        cplx_t w;
        w.re = 32'sd65536;
        w.im = 32'sd0;
        case (k)
            4'd0:  begin w.re =  32'sd65536; w.im = 32'sd0;     end
            4'd1:  begin w.re =  32'sd64277; w.im = 32'sd12785; end
            4'd2:  begin w.re =  32'sd60547; w.im = 32'sd25080; end
            4'd3:  begin w.re =  32'sd54491; w.im = 32'sd36410; end
            4'd4:  begin w.re =  32'sd46341; w.im = 32'sd46341; end
            4'd5:  begin w.re =  32'sd36410; w.im = 32'sd54491; end
            4'd6:  begin w.re =  32'sd25080; w.im = 32'sd60547; end
            4'd7:  begin w.re =  32'sd12785; w.im = 32'sd64277; end
            4'd8:  begin w.re =  32'sd0;     w.im = 32'sd65536; end
            4'd9:  begin w.re = -32'sd12785; w.im = 32'sd64277; end
            4'd10: begin w.re = -32'sd25080; w.im = 32'sd60547; end
            4'd11: begin w.re = -32'sd36410; w.im = 32'sd54491; end
            4'd12: begin w.re = -32'sd46341; w.im = 32'sd46341; end
            4'd13: begin w.re = -32'sd54491; w.im = 32'sd36410; end
            4'd14: begin w.re = -32'sd60547; w.im = 32'sd25080; end
            4'd15: begin w.re = -32'sd64277; w.im = 32'sd12785; end
            default: begin w.re = 32'sd65536; w.im = 32'sd0; end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ifft32_iter_if.sv
// Sample-in / sample-out valid-ready streams of the inverse FFT.
interface ifft32_iter_if;
    import fft32_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_r;
    logic [DATA_WIDTH-1:0] in_i;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_r;
    logic [DATA_WIDTH-1:0] out_i;
    logic                  out_last;

    modport slave (
        input  in_valid, in_r, in_i, out_ready,
        output in_ready, out_valid, out_r, out_i, out_last
    );

    modport master (
        output in_valid, in_r, in_i, out_ready,
        input  in_ready, out_valid, out_r, out_i, out_last
    );

endinterface

// File: rtl/bfly_r2_scaled.sv
// Radix-2 DIT butterfly with 1/2 scaling: a' = (a + b*w)/2, b' = (a - b*w)/2.
module bfly_r2_scaled
    import fft32_pkg::*;
(
    input  cplx_t a,
    input  cplx_t b,
    input  cplx_t w,
    output cplx_t a_new,
    output cplx_t b_new
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned SW = DATA_WIDTH + 1;

    logic signed [PW-1:0]         rr, ii, ri, ir;
    logic signed [PW-1:0]         pr_full, pi_full;
    logic signed [DATA_WIDTH-1:0] p_re, p_im;
    logic signed [SW-1:0]         s_re, s_im, d_re, d_im;
    logic                         unused_bits;

    // Full-precision complex product, truncated back to Q16.16
    always_comb begin
        rr      = PW'(b.re) * PW'(w.re);
        ii      = PW'(b.im) * PW'(w.im);
        ri      = PW'(b.re) * PW'(w.im);
        ir      = PW'(b.im) * PW'(w.re);
        pr_full = rr - ii;
        pi_full = ri + ir;
        p_re    = pr_full[FRAC_BITS +: DATA_WIDTH];
        p_im    = pi_full[FRAC_BITS +: DATA_WIDTH];
    end

    // One extra bit for the sum, then drop the LSB to halve
    always_comb begin
        s_re = SW'(a.re) + SW'(p_re);
        s_im = SW'(a.im) + SW'(p_im);
        d_re = SW'(a.re) - SW'(p_re);
        d_im = SW'(a.im) - SW'(p_im);
        a_new.re = s_re[SW-1:1];
        a_new.im = s_im[SW-1:1];
        b_new.re = d_re[SW-1:1];
        b_new.im = d_im[SW-1:1];
    end

    assign unused_bits = ^{pr_full[FRAC_BITS-1:0], pr_full[PW-1:FRAC_BITS+DATA_WIDTH],
                           pi_full[FRAC_BITS-1:0], pi_full[PW-1:FRAC_BITS+DATA_WIDTH],
                           s_re[0], s_im[0], d_re[0], d_im[0]};

endmodule

// File: rtl/ifft32_iter.sv
// 32-point iterative inverse FFT: bit-reversed load, 80-cycle in-place
// compute with one shared butterfly, natural-order unload.
module ifft32_iter
    import fft32_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    ifft32_iter_if.slave  io,
    output logic          busy
);

    state_t              state, state_d;
    logic [ADDR_W-1:0]   idx, idx_d;
    logic [STEP_W-1:0]   step, step_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;
    cplx_t               out_q, out_d;

    cplx_t               ram [NFFT_POINTS];
    logic                load_we, bfly_we;

    logic [2:0]          stage;
    logic [TW_W-1:0]     bidx;
    logic [ADDR_W-1:0]   lo_mask, top_addr, bot_addr;
    logic [TW_W-1:0]     tw_k;
    cplx_t               top_rd, bot_rd, top_new, bot_new, tw;

    assign stage = step[6:4];
    assign bidx  = step[3:0];

    // Butterfly addressing for stage s, butterfly b
    always_comb begin
        lo_mask  = (ADDR_W'(1) << stage) - ADDR_W'(1);
        top_addr = ((ADDR_W'(bidx) >> stage) << (stage + 3'd1)) | (ADDR_W'(bidx) & lo_mask);
        bot_addr = top_addr + (ADDR_W'(1) << stage);
        tw_k     = TW_W'((ADDR_W'(bidx) & lo_mask) << (3'd4 - stage));
    end

    assign top_rd = ram[top_addr];
    assign bot_rd = ram[bot_addr];
    assign tw     = twiddle_inv(tw_k);

    bfly_r2_scaled u_bfly (
        .a     (top_rd),
        .b     (bot_rd),
        .w     (tw),
        .a_new (top_new),
        .b_new (bot_new)
    );

    // Sample RAM: bit-reversed writes on load, in-place writes on compute
    always_ff @(posedge clk) begin
        if (load_we) begin
            ram[bitrev5(idx)] <= cplx_t'({io.in_r, io.in_i});
        end
        if (bfly_we) begin
            ram[top_addr] <= top_new;
            ram[bot_addr] <= bot_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            idx         <= '0;
            step        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_q       <= '0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            step        <= step_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            out_q       <= out_d;
        end
    end

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        step_d      = step;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        out_d       = out_q;
        load_we     = 1'b0;
        bfly_we     = 1'b0;
        case (state)
            LOAD: begin
                if (io.in_valid && in_ready_q) begin
                    load_we = 1'b1;
                    if (idx == ADDR_W'(NFFT_POINTS - 1)) begin
                        state_d    = COMPUTE;
                        idx_d      = '0;
                        step_d     = '0;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                    end else begin
                        idx_d = idx + ADDR_W'(1);
                    end
                end
            end
            COMPUTE: begin
                bfly_we = 1'b1;
                if (step == STEP_W'(COMPUTE_CYCLES - 1)) begin
                    // ram[0] was last written in stage 4 butterfly 0, so it is final here
                    state_d     = UNLOAD;
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    out_d       = ram[0];
                end else begin
                    step_d = step + STEP_W'(1);
                end
            end
            UNLOAD: begin
                if (out_valid_q && io.out_ready) begin
                    if (idx == ADDR_W'(NFFT_POINTS - 1)) begin
                        state_d     = LOAD;
                        idx_d       = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        in_ready_d  = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        idx_d      = idx + ADDR_W'(1);
                        out_d      = ram[idx + ADDR_W'(1)];
                        out_last_d = (idx == ADDR_W'(NFFT_POINTS - 2));
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_last  = out_last_q;
    assign io.out_r     = out_q.re;
    assign io.out_i     = out_q.im;
    assign busy         = busy_q;

endmodule
